// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter: shares one memory port between a load unit and a
// store unit, tracks a single outstanding load by tag, and flags a sticky
// error when load data never comes back.
//
// Handshake: a command is presented on proc2Dmem_* for as long as its
// requester holds req; the memory accepts it by returning a nonzero
// Dmem2proc_transaction_tag in that same cycle, and the matching ld_ack or
// st_ack pulses in that cycle. Load data is valid in the single cycle where
// Dmem2proc_data_tag equals the captured tag.
`ifndef XLEN
`define XLEN 32
`endif

module dmem_arbiter #(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ld_req,
    input  logic [`XLEN-1:0]   ld_addr,
    input  logic [1:0]         ld_size,
    output logic               ld_ack,
    output logic               ld_data_valid,
    output logic [`XLEN-1:0]   ld_data,
    input  logic               st_req,
    input  logic [`XLEN-1:0]   st_addr,
    input  logic [1:0]         st_size,
    input  logic [`XLEN-1:0]   st_data,
    output logic               st_ack,
    output logic [1:0]         proc2Dmem_command,
    output logic [`XLEN-1:0]   proc2Dmem_addr,
    output logic [`XLEN-1:0]   proc2Dmem_data,
    output logic [1:0]         proc2Dmem_size,
    input  logic [TAG_W-1:0]   Dmem2proc_transaction_tag,
    input  logic [TAG_W-1:0]   Dmem2proc_data_tag,
    input  logic [`XLEN-1:0]   Dmem2proc_data,
    output logic               load_busy,
    output logic               timeout_err,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int         CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOCK_LD, LOCK_ST, WAIT_DATA} state_t;
    typedef enum logic [1:0] {G_NONE, G_LD, G_ST} gnt_t;

    state_t             state_q, state_d;
    gnt_t               gnt_q, gnt_d;
    logic               prio_q, prio_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    gnt_t               gnt_now;
    logic               accepted;
    logic               data_hit;

    // Who owns the bus this cycle: arbitration in IDLE, the locked requester
    // in LOCK_*, and only a store may slip in while a load is outstanding.
    always_comb begin
        gnt_now = G_NONE;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (ld_req && st_req) gnt_now = prio_q ? G_ST : G_LD;
                    else if (ld_req)      gnt_now = G_LD;
                    else if (st_req)      gnt_now = G_ST;
                end
                LOCK_LD:   if (ld_req && gnt_q == G_LD) gnt_now = G_LD;
                LOCK_ST:   if (st_req && gnt_q == G_ST) gnt_now = G_ST;
                WAIT_DATA: if (st_req) gnt_now = G_ST;
                default:   gnt_now = G_NONE;
            endcase
        end
    end

    assign accepted = (gnt_now != G_NONE) && (Dmem2proc_transaction_tag != '0);
    assign data_hit = !reset && (state_q == WAIT_DATA) && (tag_q != '0)
                      && (Dmem2proc_data_tag == tag_q);

    // Bus fields follow the current grant; everything is zero when idle.
    always_comb begin
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = '0;
        proc2Dmem_data    = '0;
        proc2Dmem_size    = '0;
        case (gnt_now)
            G_LD: begin
                proc2Dmem_command = BUS_LOAD;
                proc2Dmem_addr    = ld_addr;
                proc2Dmem_size    = ld_size;
            end
            G_ST: begin
                proc2Dmem_command = BUS_STORE;
                proc2Dmem_addr    = st_addr;
                proc2Dmem_data    = st_data;
                proc2Dmem_size    = st_size;
            end
            default: ;
        endcase
    end

    assign ld_ack        = accepted && (gnt_now == G_LD);
    assign st_ack        = accepted && (gnt_now == G_ST);
    assign ld_data_valid = data_hit;
    assign ld_data       = data_hit ? Dmem2proc_data : '0;
    assign load_busy     = (state_q == WAIT_DATA);
    assign timeout_err   = err_q;
    assign dbg_state     = state_q;

    // Next-state: lock on an unaccepted grant, track the outstanding load,
    // and age it toward the timeout while no matching data arrives.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        prio_d  = prio_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE, LOCK_LD, LOCK_ST: begin
                if (gnt_now == G_NONE) begin
                    state_d = IDLE;
                    gnt_d   = G_NONE;
                end else if (accepted) begin
                    gnt_d = G_NONE;
                    if (gnt_now == G_LD) begin
                        state_d = WAIT_DATA;
                        tag_d   = Dmem2proc_transaction_tag;
                        cnt_d   = '0;
                        prio_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        prio_d  = 1'b0;
                    end
                end else begin
                    state_d = (gnt_now == G_LD) ? LOCK_LD : LOCK_ST;
                    gnt_d   = gnt_now;
                end
            end
            WAIT_DATA: begin
                if (st_ack) prio_d = 1'b0;
                if (data_hit) begin
                    state_d = IDLE;
                    tag_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    tag_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any outstanding load and its tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= G_NONE;
            prio_q  <= 1'b0;
            tag_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: drives load/store requesters and plays the memory,
// predicting each ack / data-return event at transaction level.
`ifndef XLEN
`define XLEN 32
`endif

module tb_dmem_arbiter;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int EW = 3 + 2 + 2 + 3 * 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ld_req = 1'b0, st_req = 1'b0;
    logic [`XLEN-1:0] ld_addr = '0, st_addr = '0, st_data = '0, dmem_data = '0;
    logic [1:0] ld_size = '0, st_size = '0;
    logic [3:0] trans_tag = '0, data_tag = '0;
    logic ld_ack, ld_data_valid, st_ack, load_busy, timeout_err;
    logic [`XLEN-1:0] ld_data, bus_addr, bus_data;
    logic [1:0] bus_cmd, bus_size, dbg_state;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic m_prio = 1'b0;
    logic m_err = 1'b0;

    dmem_arbiter #(.TAG_W(4), .TIMEOUT_CYCLES(64)) dut (
        .clock(clock), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
        .ld_ack(ld_ack), .ld_data_valid(ld_data_valid), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data),
        .st_ack(st_ack),
        .proc2Dmem_command(bus_cmd), .proc2Dmem_addr(bus_addr),
        .proc2Dmem_data(bus_data), .proc2Dmem_size(bus_size),
        .Dmem2proc_transaction_tag(trans_tag), .Dmem2proc_data_tag(data_tag),
        .Dmem2proc_data(dmem_data),
        .load_busy(load_busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    function automatic logic [EW-1:0] pack(input logic la, input logic sa, input logic dv,
                                           input logic [1:0] cmd, input logic [1:0] sz,
                                           input logic [31:0] a, input logic [31:0] d,
                                           input logic [31:0] ldd);
        return {la, sa, dv, cmd, sz, a, d, ldd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] noise(input logic [3:0] tg);
        logic [3:0] v;
        v = 4'($urandom_range(0, 15));
        if (v == tg) v = 4'd0;
        return v;
    endfunction

    // monitor: every ack / data pulse must match the oldest expected event
    always @(negedge clock) begin
        logic [EW-1:0] act, e;
        logic any_ack;
        if (!reset && (ld_ack || st_ack || ld_data_valid)) begin
            any_ack = ld_ack | st_ack;
            act = pack(ld_ack, st_ack, ld_data_valid,
                       any_ack ? bus_cmd : 2'd0, any_ack ? bus_size : 2'd0,
                       any_ack ? bus_addr : 32'd0, any_ack ? bus_data : 32'd0,
                       ld_data_valid ? ld_data : 32'd0);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event act=%h exp=none t=%0t", act, $time);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL event act=%h exp=%h t=%0t", act, e, $time);
                end
            end
        end
    end

    // driver: one load, optional lock cycles, optional ignored data tags
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] tg,
                           input int acc_d, input int dat_d, input logic [31:0] d);
        ld_req = 1; ld_addr = a; ld_size = sz; trans_tag = 0;
        for (int i = 0; i < acc_d; i++) begin
            #1; chk("ld_lock_cmd", 32'(bus_cmd), 32'(BUS_LOAD)); chk("ld_lock_addr", bus_addr, a);
            step();
        end
        trans_tag = tg;
        exp_q.push_back(pack(1, 0, 0, BUS_LOAD, sz, a, 0, 0));
        step();
        ld_req = 0; trans_tag = 0; m_prio = 1;
        for (int i = 0; i < dat_d; i++) begin
            data_tag = noise(tg); dmem_data = $urandom;
            #1; chk("ld_busy", 32'(load_busy), 1);
            step();
        end
        data_tag = tg; dmem_data = d;
        exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, d));
        step();
        data_tag = 0;
        #1; chk("ld_done_busy", 32'(load_busy), 0); chk("err_sticky", 32'(timeout_err), 32'(m_err));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input logic [3:0] tg, input int acc_d);
        st_req = 1; st_addr = a; st_data = d; st_size = sz; trans_tag = 0;
        for (int i = 0; i < acc_d; i++) begin
            #1; chk("st_lock_cmd", 32'(bus_cmd), 32'(BUS_STORE));
            step();
        end
        trans_tag = tg;
        exp_q.push_back(pack(0, 1, 0, BUS_STORE, sz, a, d, 0));
        step();
        st_req = 0; trans_tag = 0; m_prio = 0;
    endtask

    // both requesters at once; the model's round-robin pointer picks the winner
    task automatic do_both(input logic [31:0] la, input logic [31:0] la2, input logic [1:0] lsz,
                           input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] ssz,
                           input logic [3:0] tg, input int wd,
                           input logic [31:0] d, input logic [31:0] d2);
        ld_req = 1; ld_addr = la; ld_size = lsz;
        st_req = 1; st_addr = sa; st_data = sd; st_size = ssz;
        trans_tag = tg;
        if (m_prio == 0) begin
            exp_q.push_back(pack(1, 0, 0, BUS_LOAD, lsz, la, 0, 0));
            step();
            ld_req = 0; trans_tag = 0; m_prio = 1;
            for (int i = 0; i < wd; i++) begin
                #1; chk("wait_store_pending", 32'(bus_cmd), 32'(BUS_STORE));
                step();
            end
            data_tag = tg; dmem_data = d;
            exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, d));
            step();
            data_tag = 0;
            // back in IDLE with both pending: the store's turn now
            ld_req = 1; ld_addr = la2; trans_tag = tg;
            exp_q.push_back(pack(0, 1, 0, BUS_STORE, ssz, sa, sd, 0));
            step();
            st_req = 0; m_prio = 0;
            exp_q.push_back(pack(1, 0, 0, BUS_LOAD, lsz, la2, 0, 0));
            step();
            ld_req = 0; trans_tag = 0; m_prio = 1;
            data_tag = tg; dmem_data = d2;
            exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, d2));
            step();
            data_tag = 0;
        end else begin
            exp_q.push_back(pack(0, 1, 0, BUS_STORE, ssz, sa, sd, 0));
            step();
            st_req = 0; m_prio = 0;
            exp_q.push_back(pack(1, 0, 0, BUS_LOAD, lsz, la, 0, 0));
            step();
            ld_req = 0; trans_tag = 0; m_prio = 1;
            for (int i = 0; i < wd; i++) step();
            data_tag = tg; dmem_data = d;
            exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, d));
            step();
            data_tag = 0;
        end
    endtask

    // store issued while a load is outstanding; joint = accept with data return
    task automatic do_wait_store(input logic [31:0] la, input logic [3:0] tg,
                                 input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] sz,
                                 input int pre, input logic joint, input logic [31:0] d);
        ld_req = 1; ld_addr = la; ld_size = 2'd2; trans_tag = tg;
        exp_q.push_back(pack(1, 0, 0, BUS_LOAD, 2'd2, la, 0, 0));
        step();
        ld_req = 0; trans_tag = 0; m_prio = 1;
        st_req = 1; st_addr = sa; st_data = sd; st_size = sz;
        for (int i = 0; i < pre; i++) begin
            #1; chk("ws_cmd", 32'(bus_cmd), 32'(BUS_STORE)); chk("ws_busy", 32'(load_busy), 1);
            step();
        end
        trans_tag = 4'($urandom_range(1, 15));
        if (joint) begin
            data_tag = tg; dmem_data = d;
            exp_q.push_back(pack(0, 1, 1, BUS_STORE, sz, sa, sd, d));
            step();
            st_req = 0; trans_tag = 0; data_tag = 0; m_prio = 0;
        end else begin
            exp_q.push_back(pack(0, 1, 0, BUS_STORE, sz, sa, sd, 0));
            step();
            st_req = 0; trans_tag = 0; m_prio = 0;
            #1; chk("ws_still_busy", 32'(load_busy), 1);
            data_tag = tg; dmem_data = d;
            exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, d));
            step();
            data_tag = 0;
        end
        #1; chk("ws_idle", 32'(load_busy), 0);
    endtask

    initial begin
        logic [3:0] tg;
        // reset: outputs quiet even with requests and a tag present
        ld_req = 1; st_req = 1; ld_addr = 32'h40; trans_tag = 4'd3;
        repeat (2) step();
        chk("rst_cmd", 32'(bus_cmd), 32'(BUS_NONE));
        chk("rst_addr", bus_addr, 0);
        chk("rst_ack", 32'({ld_ack, st_ack, ld_data_valid}), 0);
        chk("rst_busy", 32'(load_busy), 0);
        chk("rst_err", 32'(timeout_err), 0);
        ld_req = 0; st_req = 0; trans_tag = 0; ld_addr = 0;
        reset = 0;
        step();

        // basic load, data two cycles after acceptance
        do_load(32'h100, 2'd2, 4'd3, 0, 1, 32'hDEADBEEF);

        // simultaneous requests with prio 1 (after a load) and prio 0
        do_both(32'h200, 32'h204, 2'd2, 32'h300, 32'h11112222, 2'd2, 4'd4, 2, 32'hA5A5A5A5, 32'h5A5A5A5A);
        do_store(32'h10, 32'h1, 2'd0, 4'd1, 0);
        do_both(32'h220, 32'h224, 2'd1, 32'h320, 32'h33334444, 2'd1, 4'd5, 1, 32'h01020304, 32'h05060708);

        // store locked for 3 unaccepted cycles, load request ignored meanwhile
        st_req = 1; st_addr = 32'h400; st_data = 32'hCAFEF00D; st_size = 2'd2; trans_tag = 0;
        #1; chk("lock_st_c1", 32'(bus_cmd), 32'(BUS_STORE));
        step();
        ld_req = 1; ld_addr = 32'h500; ld_size = 2'd2;
        for (int i = 0; i < 2; i++) begin
            #1; chk("lock_st_cmd", 32'(bus_cmd), 32'(BUS_STORE)); chk("lock_st_addr", bus_addr, 32'h400);
            step();
        end
        trans_tag = 4'd5;
        exp_q.push_back(pack(0, 1, 0, BUS_STORE, 2'd2, 32'h400, 32'hCAFEF00D, 0));
        step();
        st_req = 0; m_prio = 0; trans_tag = 4'd6;
        exp_q.push_back(pack(1, 0, 0, BUS_LOAD, 2'd2, 32'h500, 0, 0));
        step();
        ld_req = 0; trans_tag = 0; m_prio = 1;
        data_tag = 4'd6; dmem_data = 32'h600D600D;
        exp_q.push_back(pack(0, 0, 1, 0, 0, 0, 0, 32'h600D600D));
        step();
        data_tag = 0;

        // load request dropped while locked: no ack, back to IDLE
        ld_req = 1; ld_addr = 32'h700; trans_tag = 0;
        step(); step();
        ld_req = 0;
        #1; chk("drop_cmd", 32'(bus_cmd), 32'(BUS_NONE)); chk("drop_busy", 32'(load_busy), 0);
        step();
        do_store(32'h710, 32'h77, 2'd2, 4'd2, 0);

        // store accepted in the same cycle the outstanding load's data returns
        do_wait_store(32'h800, 4'd2, 32'h900, 32'h12345678, 2'd2, 2, 1'b1, 32'h87654321);

        // timeout: 64 waiting cycles, unrelated tag 7 ignored throughout
        ld_req = 1; ld_addr = 32'hA00; ld_size = 2'd2; trans_tag = 4'd2;
        exp_q.push_back(pack(1, 0, 0, BUS_LOAD, 2'd2, 32'hA00, 0, 0));
        step();
        ld_req = 0; trans_tag = 0; m_prio = 1; data_tag = 4'd7; dmem_data = 32'hBAD0BAD0;
        for (int i = 0; i < 63; i++) step();
        #1; chk("to_err_before", 32'(timeout_err), 0); chk("to_busy_before", 32'(load_busy), 1);
        step();
        m_err = 1;
        #1; chk("to_err", 32'(timeout_err), 1); chk("to_busy_after", 32'(load_busy), 0);
        data_tag = 0;
        do_load(32'hB00, 2'd2, 4'd9, 1, 2, 32'hFEEDFACE);

        // randomized mix
        for (int n = 0; n < 30; n++) begin
            tg = 4'($urandom_range(1, 15));
            case ($urandom_range(0, 4))
                0: do_load($urandom, 2'($urandom_range(0, 3)), tg, $urandom_range(0, 3),
                           $urandom_range(0, 5), $urandom);
                1: do_store($urandom, $urandom, 2'($urandom_range(0, 3)), tg, $urandom_range(0, 3));
                2: do_both($urandom, $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom,
                           2'($urandom_range(0, 3)), tg, $urandom_range(0, 4), $urandom, $urandom);
                3: do_wait_store($urandom, tg, $urandom, $urandom, 2'($urandom_range(0, 3)),
                                 $urandom_range(0, 3), 1'b1, $urandom);
                default: do_wait_store($urandom, tg, $urandom, $urandom, 2'($urandom_range(0, 3)),
                                       $urandom_range(0, 3), 1'b0, $urandom);
            endcase
        end

        // reset in WAIT_DATA abandons the load; its tag later is ignored
        ld_req = 1; ld_addr = 32'hC00; ld_size = 2'd2; trans_tag = 4'd11;
        exp_q.push_back(pack(1, 0, 0, BUS_LOAD, 2'd2, 32'hC00, 0, 0));
        step();
        ld_req = 0; trans_tag = 0; m_prio = 1;
        step();
        reset = 1;
        #1; chk("midrst_busy", 32'(load_busy), 0); chk("midrst_err", 32'(timeout_err), 0);
        chk("midrst_cmd", 32'(bus_cmd), 32'(BUS_NONE));
        step();
        reset = 0; m_prio = 0; m_err = 0;
        data_tag = 4'd11; dmem_data = 32'h99999999;
        #1; chk("midrst_no_data", 32'(ld_data_valid), 0);
        step();
        data_tag = 0;
        // prio back to 0 after reset: load wins the tie again
        do_both(32'hD00, 32'hD04, 2'd2, 32'hE00, 32'hE0E0E0E0, 2'd2, 4'd3, 1, 32'h13579BDF, 32'h2468ACE0);

        step();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
